// File: rtl/scpu_dbg_pkg.sv
// rtl/scpu_dbg_pkg.sv - shared encodings for the sccomp run/debug controller
package scpu_dbg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2,
        ST_DUMP = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        OP_RUN  = 2'd0,
        OP_STEP = 2'd1,
        OP_DUMP = 2'd2,
        OP_RSVD = 2'd3
    } cmd_op_t;

    typedef enum logic [2:0] {
        HC_RESET     = 3'd0,
        HC_HALT_REQ  = 3'd1,
        HC_BREAK     = 3'd2,
        HC_LIMIT     = 3'd3,
        HC_FAULT     = 3'd4,
        HC_STEP_DONE = 3'd5
    } halt_cause_t;

    localparam logic [4:0] REG_LAST = 5'd31;

endpackage

// File: rtl/scpu_reg_dump.sv
// rtl/scpu_reg_dump.sv - walks reg_sel over all 32 registers and streams them out
module scpu_reg_dump
    import scpu_dbg_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic [31:0] reg_data,
    input  logic        dump_ready,
    output logic [4:0]  reg_sel,
    output logic        dump_valid,
    output logic [4:0]  dump_idx,
    output logic [31:0] dump_data,
    output logic        done
);

    logic active;

    assign done = dump_valid && dump_ready && (dump_idx == REG_LAST);

    // reg_sel is presented one cycle before its word is captured, so the
    // combinational register-file read has a full cycle to settle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            active     <= 1'b0;
            reg_sel    <= 5'd0;
            dump_valid <= 1'b0;
            dump_idx   <= 5'd0;
            dump_data  <= 32'd0;
        end else if (start) begin
            active     <= 1'b1;
            reg_sel    <= 5'd0;
            dump_valid <= 1'b0;
        end else if (active) begin
            if (!dump_valid) begin
                dump_valid <= 1'b1;
                dump_idx   <= reg_sel;
                dump_data  <= reg_data;
            end else if (dump_ready) begin
                dump_valid <= 1'b0;
                if (dump_idx == REG_LAST) begin
                    active  <= 1'b0;
                    reg_sel <= 5'd0;
                end else begin
                    reg_sel <= reg_sel + 5'd1;
                end
            end
        end
    end

endmodule

// File: rtl/scpu_run_ctrl.sv
// rtl/scpu_run_ctrl.sv - run/step/breakpoint/watchdog controller gating the sccomp CPU clock-enable
module scpu_run_ctrl
    import scpu_dbg_pkg::*;
#(
    parameter int unsigned MAX_INSTR  = 1000,
    parameter logic [31:0] IMEM_BYTES = 32'h0000_0400
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        cmd_valid,
    input  logic [1:0]  cmd_op,
    input  logic [31:0] cmd_arg,
    output logic        cmd_ready,
    input  logic        halt_req,
    input  logic        bp_en,
    input  logic [31:0] bp_addr,
    input  logic [31:0] pc_i,
    output logic        cpu_en,
    output logic [4:0]  reg_sel,
    input  logic [31:0] reg_data,
    output logic        dump_valid,
    output logic [4:0]  dump_idx,
    output logic [31:0] dump_data,
    input  logic        dump_ready,
    output logic        halted,
    output logic [2:0]  halt_cause,
    output logic [31:0] instr_cnt
);

    state_t      state, state_nxt;
    halt_cause_t cause_q, stop_cause;
    logic [31:0] step_left;
    logic        first_flag;
    logic        in_exec, accept, go_exec, dump_start, dump_done;
    logic        fault, brk, lim, stop;
    cmd_op_t     op;

    assign op         = cmd_op_t'(cmd_op);
    assign cmd_ready  = (state == ST_IDLE);
    assign halted     = (state == ST_IDLE);
    assign halt_cause = cause_q;
    assign accept     = cmd_valid && cmd_ready;
    assign go_exec    = accept && (op == OP_RUN || op == OP_STEP);
    assign dump_start = accept && (op == OP_DUMP);
    assign in_exec    = (state == ST_RUN) || (state == ST_STEP);

    // first_flag masks the breakpoint so a run can resume from the break PC.
    assign fault = (pc_i >= IMEM_BYTES) || (pc_i[1:0] != 2'b00);
    assign brk   = bp_en && (pc_i == bp_addr) && !first_flag;
    assign lim   = (state == ST_RUN) && (instr_cnt == 32'(MAX_INSTR));
    assign stop  = in_exec && (fault || brk || lim || halt_req);

    assign cpu_en = in_exec && !stop;

    always_comb begin
        stop_cause = HC_HALT_REQ;
        if (fault)    stop_cause = HC_FAULT;
        else if (brk) stop_cause = HC_BREAK;
        else if (lim) stop_cause = HC_LIMIT;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    case (op)
                        OP_RUN:  state_nxt = ST_RUN;
                        OP_STEP: state_nxt = ST_STEP;
                        OP_DUMP: state_nxt = ST_DUMP;
                        default: state_nxt = ST_IDLE;
                    endcase
                end
            end
            ST_RUN:  if (stop) state_nxt = ST_IDLE;
            ST_STEP: if (stop || step_left == 32'd1) state_nxt = ST_IDLE;
            ST_DUMP: if (dump_done) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= ST_IDLE;
            cause_q    <= HC_RESET;
            instr_cnt  <= 32'd0;
            step_left  <= 32'd0;
            first_flag <= 1'b0;
        end else begin
            state <= state_nxt;
            if (go_exec) begin
                instr_cnt  <= 32'd0;
                first_flag <= 1'b1;
                step_left  <= (cmd_arg == 32'd0) ? 32'd1 : cmd_arg;
            end
            if (in_exec) begin
                first_flag <= 1'b0;
                if (stop) cause_q <= stop_cause;
            end
            if (cpu_en) begin
                if (instr_cnt != 32'hFFFF_FFFF) instr_cnt <= instr_cnt + 32'd1;
                step_left <= step_left - 32'd1;
                if (state == ST_STEP && step_left == 32'd1) cause_q <= HC_STEP_DONE;
            end
        end
    end

    scpu_reg_dump u_reg_dump (
        .clk        (clk),
        .rstn       (rstn),
        .start      (dump_start),
        .reg_data   (reg_data),
        .dump_ready (dump_ready),
        .reg_sel    (reg_sel),
        .dump_valid (dump_valid),
        .dump_idx   (dump_idx),
        .dump_data  (dump_data),
        .done       (dump_done)
    );

endmodule

// File: tb/tb_scpu_run_ctrl.sv
// tb/tb_scpu_run_ctrl.sv - directed bench with a CPU/register-file model and result scoreboards
module tb_scpu_run_ctrl;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [1:0]  cmd_op = 2'd0;
    logic [31:0] cmd_arg = 32'd0;
    logic        cmd_ready;
    logic        halt_req = 1'b0;
    logic        bp_en = 1'b0;
    logic [31:0] bp_addr = 32'd0;
    logic [31:0] pc = 32'd0;
    logic        cpu_en;
    logic [4:0]  reg_sel;
    logic [31:0] reg_data;
    logic        dump_valid;
    logic [4:0]  dump_idx;
    logic [31:0] dump_data;
    logic        dump_ready = 1'b0;
    logic        halted;
    logic [2:0]  halt_cause;
    logic [31:0] instr_cnt;

    logic [31:0] rf [32];
    int          mode = 0;
    logic        load_req = 1'b0;
    logic [31:0] load_val = 32'd0;
    int unsigned pulses = 0;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        logic [2:0]  cause;
        logic [31:0] cnt;
    } res_t;
    res_t        run_q[$];
    logic [36:0] dump_q[$];

    always #5 clk = ~clk;

    scpu_run_ctrl #(.MAX_INSTR(1000), .IMEM_BYTES(32'h0000_0400)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .cmd_valid  (cmd_valid),
        .cmd_op     (cmd_op),
        .cmd_arg    (cmd_arg),
        .cmd_ready  (cmd_ready),
        .halt_req   (halt_req),
        .bp_en      (bp_en),
        .bp_addr    (bp_addr),
        .pc_i       (pc),
        .cpu_en     (cpu_en),
        .reg_sel    (reg_sel),
        .reg_data   (reg_data),
        .dump_valid (dump_valid),
        .dump_idx   (dump_idx),
        .dump_data  (dump_data),
        .dump_ready (dump_ready),
        .halted     (halted),
        .halt_cause (halt_cause),
        .instr_cnt  (instr_cnt)
    );

    assign reg_data = rf[reg_sel];

    // Mode 0: straight-line code. Mode 1: two-instruction loop 0x4C <-> 0x50.
    function automatic logic [31:0] next_pc(logic [31:0] p, int m);
        if (m == 1 && p == 32'h50) return 32'h4C;
        return p + 32'd4;
    endfunction

    always @(posedge clk) begin
        if (load_req) pc <= load_val;
        else if (cpu_en) pc <= next_pc(pc, mode);
        if (cpu_en) pulses <= pulses + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pc(input logic [31:0] v);
        load_val = v;
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] arg);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_halt(input string tag, input int budget);
        int n = 0;
        while (!halted && n < budget) begin
            tick();
            n++;
        end
        chk({tag, "_halt_in_time"}, 32'(halted), 32'd1);
    endtask

    task automatic run_cmd(input string tag, input logic [1:0] op, input logic [31:0] arg,
                           input logic [2:0] ecause, input logic [31:0] ecnt);
        int unsigned p0;
        res_t r;
        p0 = pulses;
        run_q.push_back('{ecause, ecnt});
        issue(op, arg);
        wait_halt(tag, 3000);
        if (run_q.size() > 0) begin
            r = run_q.pop_front();
            chk({tag, "_cause"}, 32'(halt_cause), 32'(r.cause));
            chk({tag, "_cnt"}, instr_cnt, r.cnt);
            chk({tag, "_pulses"}, pulses - p0, r.cnt);
        end
        chk({tag, "_cpu_en_idle"}, 32'(cpu_en), 32'd0);
    endtask

    initial begin
        logic [36:0] w;
        int          n;
        bit          stalled;
        for (int i = 0; i < 32; i++) rf[i] = 32'h100 + 32'(i) * 32'h11;
        rf[7] = 32'h1234;

        #12;
        chk("rst_halted", 32'(halted), 32'd1);
        chk("rst_cause", 32'(halt_cause), 32'd0);
        chk("rst_cpu_en", 32'(cpu_en), 32'd0);
        chk("rst_cnt", instr_cnt, 32'd0);
        chk("rst_dump_valid", 32'(dump_valid), 32'd0);
        chk("rst_reg_sel", 32'(reg_sel), 32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        rstn = 1'b1;
        tick();

        issue(2'd3, 32'd0);
        chk("rsvd_halted", 32'(halted), 32'd1);
        chk("rsvd_cause", 32'(halt_cause), 32'd0);

        mode = 0;
        set_pc(32'h0);
        bp_en = 1'b1;
        bp_addr = 32'h48;
        run_cmd("break", 2'd0, 32'd0, 3'd2, 32'd18);
        chk("break_pc", pc, 32'h48);

        mode = 1;
        run_cmd("limit", 2'd0, 32'd0, 3'd3, 32'd1000);

        run_cmd("step3", 2'd1, 32'd3, 3'd5, 32'd3);
        run_cmd("step0", 2'd1, 32'd0, 3'd5, 32'd1);

        mode = 0;
        set_pc(32'h3F8);
        run_cmd("fault_oob", 2'd0, 32'd0, 3'd4, 32'd2);
        chk("fault_oob_pc", pc, 32'h400);

        set_pc(32'h46);
        run_cmd("fault_align", 2'd0, 32'd0, 3'd4, 32'd0);

        set_pc(32'h3FC);
        bp_addr = 32'h400;
        run_cmd("fault_vs_bp", 2'd0, 32'd0, 3'd4, 32'd1);

        bp_en = 1'b0;
        set_pc(32'h0);
        halt_req = 1'b1;
        run_cmd("halt_req", 2'd0, 32'd0, 3'd1, 32'd0);
        halt_req = 1'b0;

        for (int i = 0; i < 32; i++) dump_q.push_back({5'(i), rf[i]});
        issue(2'd2, 32'd0);
        stalled = 0;
        while (dump_q.size() > 0) begin
            n = 0;
            while (!dump_valid && n < 10) begin
                tick();
                n++;
            end
            chk("dump_valid_in_time", 32'(dump_valid), 32'd1);
            if (!dump_valid) break;
            if (dump_idx == 5'd7 && !stalled) begin
                stalled = 1;
                for (int s = 0; s < 3; s++) begin
                    tick();
                    chk("stall_reg_sel", 32'(reg_sel), 32'd7);
                    chk("stall_valid", 32'(dump_valid), 32'd1);
                end
            end
            w = dump_q.pop_front();
            chk("dump_idx", 32'(dump_idx), 32'(w[36:32]));
            chk("dump_data", dump_data, w[31:0]);
            dump_ready = 1'b1;
            tick();
            dump_ready = 1'b0;
        end
        chk("dump_end_halted", 32'(halted), 32'd1);
        chk("dump_end_valid", 32'(dump_valid), 32'd0);
        chk("dump_end_reg_sel", 32'(reg_sel), 32'd0);
        chk("dump_end_cause", 32'(halt_cause), 32'd1);

        issue(2'd2, 32'd0);
        n = 0;
        while (!(dump_valid && dump_idx == 5'd12) && n < 100) begin
            if (dump_valid) dump_ready = 1'b1;
            tick();
            dump_ready = 1'b0;
            n++;
        end
        chk("reach_idx12", 32'(dump_idx), 32'd12);
        rstn = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(dump_valid), 32'd0);
        chk("mid_rst_cause", 32'(halt_cause), 32'd0);
        chk("mid_rst_halted", 32'(halted), 32'd1);
        chk("mid_rst_cpu_en", 32'(cpu_en), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        tick();
        chk("post_rst_ready", 32'(cmd_ready), 32'd1);
        chk("post_rst_reg_sel", 32'(reg_sel), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/scpu_run_ctrl.md
Name: scpu_run_ctrl

Overview:
- Run/debug controller for the single-cycle CPU in sccomp; sequences execution through a CPU clock-enable.
- Supports free-run, N-step, breakpoint-on-PC, instruction-limit watchdog, PC-fault halt and a 32-register dump via the sccomp reg_sel/reg_data port.
- Moves bench-style run/stop policy into synthesizable RTL between the host/debug interface and U_SCPU.

Parameters:
- MAX_INSTR, 1000, instructions committed per RUN before forced halt (LIMIT).
- IMEM_BYTES, 32'h0000_0400, instruction-memory size; pc_i >= IMEM_BYTES is a fault.

Ports:
- clk  in  1  system clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command strobe.
- cmd_op  in  2  0=RUN, 1=STEP, 2=DUMP, 3=reserved (ignored, no state change).
- cmd_arg  in  32  STEP count (0 treated as 1); unused otherwise.
- cmd_ready  out  1  high only in IDLE.
- halt_req  in  1  level; stop RUN/STEP before next commit.
- bp_en  in  1  breakpoint enable.
- bp_addr  in  32  breakpoint PC.
- pc_i  in  32  CPU PC of instruction about to commit (combinational from U_SCPU).
- cpu_en  out  1  CPU commits one instruction at each rising edge where high.
- reg_sel  out  5  register index to sccomp.
- reg_data  in  32  sccomp register read data (combinational on reg_sel).
- dump_valid  out  1  dump word available.
- dump_idx  out  5  register index of dump_data.
- dump_data  out  32  register value.
- dump_ready  in  1  consumer accepts word.
- halted  out  1  high in IDLE.
- halt_cause  out  3  0=RESET,1=HALT_REQ,2=BREAK,3=LIMIT,4=FAULT,5=STEP_DONE.
- instr_cnt  out  32  instructions committed since last RUN/STEP accept.

Behaviour:
- Reset (async, any state): state=IDLE, cpu_en=0, reg_sel=0, dump_valid=0, dump_idx=0, dump_data=0, halted=1, halt_cause=RESET, instr_cnt=0, first_flag=0.
- States: IDLE, RUN, STEP, DUMP. Command accepted on clk edge with cmd_valid&&cmd_ready.
- Accept RUN/STEP: instr_cnt<=0, first_flag<=1, step_left<=max(cmd_arg,1); go RUN/STEP. Accept DUMP: reg_sel<=0, go DUMP.
- cpu_en combinational: high in RUN/STEP iff no stop condition this cycle; low in IDLE/DUMP.
- Stop conditions, priority: FAULT (pc_i>=IMEM_BYTES or pc_i[1:0]!=0) > BREAK (bp_en && pc_i==bp_addr && !first_flag) > LIMIT (RUN only, instr_cnt==MAX_INSTR) > HALT_REQ. On stop: cpu_en=0 that cycle, next state IDLE, halt_cause latched; the stopping instruction does not commit.
- first_flag cleared after first cycle in RUN/STEP; permits resume from a breakpoint PC.
- Each commit cycle: instr_cnt+1. STEP: step_left-1; on commit with step_left==1 -> IDLE, cause STEP_DONE (same edge as last commit).
- DUMP: reg_sel drives index k; word k captured into dump_data/dump_idx with dump_valid=1 one cycle after reg_sel=k; reg_sel held while dump_valid&&!dump_ready. On accept, k+1 captured next cycle (max 1 word per 2 cycles). After accepting idx 31: dump_valid=0, reg_sel=0, IDLE; halt_cause unchanged.
- halt_req in IDLE/DUMP has no effect. cmd_valid outside IDLE ignored (not queued).
- Reset mid-DUMP/RUN: immediate IDLE, partial dump discarded, cpu_en=0 asynchronously.
- instr_cnt saturates at 32'hFFFF_FFFF (STEP only).

Decomposition:
- Shared package/header scpu_dbg_pkg: state encodings, cmd_op codes, halt_cause codes.
- Sub-module scpu_reg_dump: reg_sel/dump handshake sequencer with start/done; top holds run FSM, counters, stop logic.

Test Plan:
- Reset then RUN, bp_en=1, bp_addr=0x48, program straight-line from 0 -> halt_cause=BREAK, pc_i=0x48, instr_cnt=18, cpu_en=0 in IDLE.
- Resume RUN at 0x48 with the breakpoint still armed -> first cycle commits (no re-break); loop reaching MAX_INSTR=1000 -> halt_cause=LIMIT, instr_cnt=1000.
- STEP cmd_arg=3 -> exactly 3 cpu_en pulses, halt_cause=STEP_DONE; STEP cmd_arg=0 -> 1 pulse.
- Branch to pc=0x400 during RUN -> halt_cause=FAULT with 0 commits at 0x400; pc=0x46 -> FAULT; fault+breakpoint same cycle -> FAULT.
- DUMP with rf[7]=0x1234 and dump_ready stalled 3 cycles on idx 7 -> reg_sel holds 7, 32 words idx 0..31 in order, dump_data=0x1234 at idx 7, then IDLE.
- rstn low mid-DUMP at idx 12 -> dump_valid=0 immediately, halt_cause=RESET, cmd_ready=1 after release.
